// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry record, fence FSM states,
// and the byte-offset width used by the forwarding address compare.
package store_buffer_pkg;

    localparam int SB_XLEN  = 64;
    localparam int SB_BYTES = SB_XLEN / 8;
    localparam int OFS_W    = $clog2(SB_BYTES);

    typedef struct packed {
        logic                valid;
        logic [SB_XLEN-1:0]  address;
        logic [SB_XLEN-1:0]  value;
        logic [SB_BYTES-1:0] byte_en;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FENCE,
        DONE
    } sb_state_e;

endpackage

// File: rtl/store_buffer_ctrl_fwd.sv
// store_fwd_merge: per-lane youngest-match merge of buffered stores,
// walking entries from the head (oldest) so younger writes win.
module store_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t           entries [DEPTH],
    input  logic [PW-1:0]       head,
    input  logic [SB_XLEN-1:0]  fwd_address,
    output logic [SB_XLEN-1:0]  fwd_value,
    output logic [SB_BYTES-1:0] fwd_byte_en
);

    logic [PW-1:0] idx;
    sb_entry_t     cur;
    logic          unused_ofs;

    assign unused_ofs = ^fwd_address[OFS_W-1:0];

    always_comb begin
        fwd_value   = '0;
        fwd_byte_en = '0;
        idx         = head;
        cur         = entries[head];
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            cur = entries[idx];
            if (cur.valid &&
                cur.address[SB_XLEN-1:OFS_W] == fwd_address[SB_XLEN-1:OFS_W]) begin
                for (int b = 0; b < SB_BYTES; b++) begin
                    if (cur.byte_en[b]) begin
                        fwd_value[b*8 +: 8] = cur.value[b*8 +: 8];
                        fwd_byte_en[b]      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Committed-store FIFO with in-order drain, fence handshake and load
// forwarding (forwarding compiled in only when STORE_FWD_EN is defined).
module store_buffer_ctrl
    import store_buffer_pkg::*;
#(
    parameter int XLEN           = SB_XLEN,
    parameter int DEPTH          = 8,
    parameter int HIGH_WATERMARK = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   commit_valid,
    output logic                   commit_ready,
    input  logic [XLEN-1:0]        commit_address,
    input  logic [XLEN-1:0]        commit_value,
    input  logic [XLEN/8-1:0]      commit_byte_en,
    output logic                   store_request_valid,
    input  logic                   store_request_ready,
    output logic [XLEN-1:0]        store_request_address,
    output logic [XLEN-1:0]        store_request_value,
    output logic [XLEN/8-1:0]      store_request_byte_en,
    input  logic [XLEN-1:0]        fwd_address,
    output logic                   fwd_hit,
    output logic [XLEN-1:0]        fwd_value,
    output logic [XLEN/8-1:0]      fwd_byte_en,
    input  logic                   fence_request,
    output logic                   fence_done,
    output logic                   store_urgent,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HWM      = CW'(HIGH_WATERMARK);

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    sb_state_e     state;
    sb_state_e     state_next;
    logic          enq;
    logic          deq;

    assign full                  = (count_q == FULL_CNT);
    assign empty                 = (count_q == '0);
    assign count                 = count_q;
    assign store_urgent          = (count_q >= HWM);
    assign commit_ready          = ~full && (state == IDLE);
    assign store_request_valid   = ~empty;
    assign store_request_address = entries[head].address;
    assign store_request_value   = entries[head].value;
    assign store_request_byte_en = entries[head].byte_en;
    assign fence_done            = (state == DONE);
    assign enq                   = commit_valid && commit_ready;
    assign deq                   = store_request_valid && store_request_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (deq) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_ONE;
            end
            if (enq) begin
                entries[tail] <= '{valid:   1'b1,
                                   address: commit_address,
                                   value:   commit_value,
                                   byte_en: commit_byte_en};
                tail          <= tail + PTR_ONE;
            end
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fence seen while already empty still passes through FENCE for a cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fence_request) state_next = FENCE;
            FENCE:   if (count_q == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef STORE_FWD_EN
    store_fwd_merge #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fwd (
        .entries     (entries),
        .head        (head),
        .fwd_address (fwd_address),
        .fwd_value   (fwd_value),
        .fwd_byte_en (fwd_byte_en)
    );
    assign fwd_hit = |fwd_byte_en;
`else
    logic unused_fwd;
    assign unused_fwd  = ^fwd_address;
    assign fwd_hit     = 1'b0;
    assign fwd_value   = '0;
    assign fwd_byte_en = '0;
`endif

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_store_buffer_ctrl;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int HWM   = 6;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              commit_valid;
    logic              commit_ready;
    logic [XLEN-1:0]   commit_address;
    logic [XLEN-1:0]   commit_value;
    logic [XLEN/8-1:0] commit_byte_en;
    logic              store_request_valid;
    logic              store_request_ready;
    logic [XLEN-1:0]   store_request_address;
    logic [XLEN-1:0]   store_request_value;
    logic [XLEN/8-1:0] store_request_byte_en;
    logic [XLEN-1:0]   fwd_address;
    logic              fwd_hit;
    logic [XLEN-1:0]   fwd_value;
    logic [XLEN/8-1:0] fwd_byte_en;
    logic              fence_request;
    logic              fence_done;
    logic              store_urgent;
    logic              empty;
    logic              full;
    logic [3:0]        count;

    store_buffer_ctrl #(
        .XLEN           (XLEN),
        .DEPTH          (DEPTH),
        .HIGH_WATERMARK (HWM)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .commit_valid          (commit_valid),
        .commit_ready          (commit_ready),
        .commit_address        (commit_address),
        .commit_value          (commit_value),
        .commit_byte_en        (commit_byte_en),
        .store_request_valid   (store_request_valid),
        .store_request_ready   (store_request_ready),
        .store_request_address (store_request_address),
        .store_request_value   (store_request_value),
        .store_request_byte_en (store_request_byte_en),
        .fwd_address           (fwd_address),
        .fwd_hit               (fwd_hit),
        .fwd_value             (fwd_value),
        .fwd_byte_en           (fwd_byte_en),
        .fence_request         (fence_request),
        .fence_done            (fence_done),
        .store_urgent          (store_urgent),
        .empty                 (empty),
        .full                  (full),
        .count                 (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] v;
        logic [7:0]  be;
    } st_t;

    st_t q[$];
    bit  f_busy;
    bit  f_done;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] ref_fwd(logic [63:0] fa);
        logic [63:0] val = '0;
        logic [7:0]  be  = '0;
        foreach (q[k]) begin
            if ((q[k].a >> 3) == (fa >> 3)) begin
                for (int b = 0; b < 8; b++) begin
                    if (q[k].be[b]) begin
                        val[b*8 +: 8] = q[k].v[b*8 +: 8];
                        be[b]         = 1'b1;
                    end
                end
            end
        end
        if (!FWD) begin
            val = '0;
            be  = '0;
        end
        return {be, val};
    endfunction

    function automatic bit m_ready();
        return (q.size() < DEPTH) && !f_busy && !f_done;
    endfunction

    task automatic check_model(string tag);
        logic [71:0] f;
        f = ref_fwd(fwd_address);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
        chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
        chk({tag, ".commit_ready"}, 64'(commit_ready), 64'(m_ready()));
        chk({tag, ".req_valid"}, 64'(store_request_valid), 64'(q.size() != 0));
        chk({tag, ".urgent"}, 64'(store_urgent), 64'(q.size() >= HWM));
        chk({tag, ".fence_done"}, 64'(fence_done), 64'(f_done));
        chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(|f[71:64]));
        chk({tag, ".fwd_be"}, 64'(fwd_byte_en), 64'(f[71:64]));
        chk({tag, ".fwd_val"}, fwd_value, f[63:0]);
        if (q.size() != 0) begin
            chk({tag, ".req_addr"}, store_request_address, q[0].a);
            chk({tag, ".req_val"}, store_request_value, q[0].v);
            chk({tag, ".req_be"}, 64'(store_request_byte_en), 64'(q[0].be));
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".empty"}, 64'(empty), 64'd1);
        chk({tag, ".full"}, 64'(full), 64'd0);
        chk({tag, ".commit_ready"}, 64'(commit_ready), 64'd1);
        chk({tag, ".req_valid"}, 64'(store_request_valid), 64'd0);
        chk({tag, ".req_addr"}, store_request_address, 64'd0);
        chk({tag, ".req_val"}, store_request_value, 64'd0);
        chk({tag, ".req_be"}, 64'(store_request_byte_en), 64'd0);
        chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'd0);
        chk({tag, ".fwd_be"}, 64'(fwd_byte_en), 64'd0);
        chk({tag, ".fwd_val"}, fwd_value, 64'd0);
        chk({tag, ".fence_done"}, 64'(fence_done), 64'd0);
        chk({tag, ".urgent"}, 64'(store_urgent), 64'd0);
    endtask

    task automatic model_clear();
        q.delete();
        f_busy = 1'b0;
        f_done = 1'b0;
    endtask

    task automatic drive(bit cv, logic [63:0] a, logic [63:0] v,
                         logic [7:0] be, bit srr, logic [63:0] fa, bit fence);
        commit_valid        = cv;
        commit_address      = a;
        commit_value        = v;
        commit_byte_en      = be;
        store_request_ready = srr;
        fwd_address         = fa;
        fence_request       = fence;
    endtask

    task automatic cycle(string tag);
        bit  acc;
        bit  drn;
        int  sz;
        st_t nw;
        acc = commit_valid && m_ready();
        drn = store_request_ready && (q.size() != 0);
        sz  = q.size();
        nw  = '{a: commit_address, v: commit_value, be: commit_byte_en};
        @(posedge clock);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(nw);
        if (f_done) begin
            f_done = 1'b0;
        end else if (f_busy) begin
            if (sz == 0) begin
                f_busy = 1'b0;
                f_done = 1'b1;
            end
        end else if (fence_request) begin
            f_busy = 1'b1;
        end
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit          cv;
        logic [63:0] a;
        logic [63:0] v;
        logic [7:0]  be;
        bit          srr;
        logic [63:0] fa;
        int          ecnt;
        logic [7:0]  efbe;
        logic [63:0] efv;
    } vec_t;

    vec_t        vt[8];
    logic [63:0] pool[5];

    initial begin
        logic [71:0] f;
        logic [63:0] wa[20];
        logic [63:0] wv[20];
        int          pulses;

        vt[0] = '{1, 64'h100, 64'h1122334455667788, 8'h0F, 0, 64'h100, 1, 8'h0F, 64'h0000000055667788};
        vt[1] = '{1, 64'h104, 64'hAAAABBBB00000000, 8'h30, 0, 64'h100, 2, 8'h3F, 64'h0000BBBB55667788};
        vt[2] = '{0, 64'h0,   64'h0,                8'h00, 0, 64'h108, 2, 8'h00, 64'h0};
        vt[3] = '{1, 64'h100, 64'h00000000000000EE, 8'h01, 0, 64'h100, 3, 8'h3F, 64'h0000BBBB556677EE};
        vt[4] = '{1, 64'h200, 64'h0102030405060708, 8'hFF, 1, 64'h100, 3, 8'h31, 64'h0000BBBB000000EE};
        vt[5] = '{0, 64'h0,   64'h0,                8'h00, 1, 64'h200, 2, 8'hFF, 64'h0102030405060708};
        vt[6] = '{0, 64'h0,   64'h0,                8'h00, 1, 64'h100, 1, 8'h00, 64'h0};
        vt[7] = '{0, 64'h0,   64'h0,                8'h00, 1, 64'h200, 0, 8'h00, 64'h0};
        pool  = '{64'h100, 64'h104, 64'h108, 64'h200, 64'h204};

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h100, 0);
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_reset("rst");
        reset = 1'b1;
        cycle("idle");

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].cv, vt[i].a, vt[i].v, vt[i].be, vt[i].srr, vt[i].fa, 0);
            #1;
            f = ref_fwd(fwd_address);
            chk("tbl_pre_fwd_be", 64'(fwd_byte_en), 64'(f[71:64]));
            cycle("tbl");
            chk("tbl_count", 64'(count), 64'(vt[i].ecnt));
            chk("tbl_fwd_be", 64'(fwd_byte_en), FWD ? 64'(vt[i].efbe) : 64'd0);
            chk("tbl_fwd_val", fwd_value, FWD ? vt[i].efv : 64'd0);
            chk("tbl_fwd_hit", 64'(fwd_hit), FWD ? 64'(vt[i].efbe != 0) : 64'd0);
        end

        for (int i = 0; i < 8; i++) begin
            drive(1, 64'h1000 + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 64'h1000, 0);
            cycle("fill");
            chk("fill_urgent", 64'(store_urgent), 64'(i + 1 >= HWM));
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(commit_ready), 64'd0);
        drive(1, 64'h5000, 64'h55, 8'hFF, 1, 64'h0, 0);
        cycle("full_rej");
        chk("full_rej_count", 64'(count), 64'd7);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 1, 64'h0, 0);
            chk("drain_addr", store_request_address, 64'h1000 + 64'(8 * (i + 1)));
            cycle("drain");
        end
        chk("drain_empty", 64'(empty), 64'd1);

        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h3000 + 64'(8 * i), {$urandom, $urandom}, 8'hF0, 0, 64'h0, 0);
            cycle("fq_fill");
        end
        drive(0, 0, 0, 0, 0, 64'h0, 1);
        cycle("fence_req");
        for (int i = 0; i < 2; i++) begin
            drive(1, 64'h7000, 64'h77, 8'hFF, 0, 64'h0, 0);
            cycle("fence_hold");
            chk("fence_block_ready", 64'(commit_ready), 64'd0);
            chk("fence_block_count", 64'(count), 64'd4);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 1, 64'h0, 0);
            cycle("fence_drain");
            if (fence_done) begin
                pulses++;
                chk("fence_done_empty", 64'(empty), 64'd1);
            end
        end
        chk("fence_pulses", 64'(pulses), 64'd1);
        chk("fence_ready_back", 64'(commit_ready), 64'd1);

        drive(0, 0, 0, 0, 0, 64'h0, 1);
        cycle("fence_e0");
        chk("fence_e_d0", 64'(fence_done), 64'd0);
        drive(0, 0, 0, 0, 0, 64'h0, 0);
        cycle("fence_e1");
        chk("fence_e_d1", 64'(fence_done), 64'd1);
        cycle("fence_e2");
        chk("fence_e_d2", 64'(fence_done), 64'd0);

        for (int i = 0; i < 20; i++) begin
            wa[i] = {$urandom, $urandom} & ~64'h7;
            wv[i] = {$urandom, $urandom};
            drive(1, wa[i], wv[i], 8'hFF, 0, 64'h0, 0);
            cycle("wrap_enq");
            drive(0, 0, 0, 0, 1, 64'h0, 0);
            chk("wrap_addr", store_request_address, wa[i]);
            chk("wrap_val", store_request_value, wv[i]);
            cycle("wrap_deq");
        end

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, pool[$urandom_range(0, 4)],
                  {$urandom, $urandom}, 8'($urandom),
                  (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  pool[$urandom_range(0, 4)] + 64'($urandom_range(0, 7)),
                  $urandom_range(0, 24) == 0);
            cycle("rand");
        end

        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 1, 64'h0, 0);
            cycle("pre_rst_drain");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 64'h9000 + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 64'h9000, 0);
            cycle("rst_fill");
        end
        drive(0, 0, 0, 0, 0, 64'h9000, 1);
        cycle("rst_fence");
        drive(0, 0, 0, 0, 1, 64'h9000, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset("mid_rst");
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 64'h9000, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("post_rst");
            chk("post_rst_no_done", 64'(fence_done), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
